// File: rtl/slv_pkg.sv
// Shared slave-side types: regbus request/response, register offsets and
// the packed layouts of the monitor control and status registers.
package slv_pkg;

   localparam int unsigned CntWidth      = 3;
   localparam int unsigned AxiIntIdWidth = 1;
   localparam int unsigned RegAddrWidth  = 32;
   localparam int unsigned RegDataWidth  = 32;

   typedef struct packed {
      logic [RegAddrWidth-1:0]   addr;
      logic                      write;
      logic [RegDataWidth-1:0]   wdata;
      logic [RegDataWidth/8-1:0] wstrb;
      logic                      valid;
   } reg_req_t;

   typedef struct packed {
      logic [RegDataWidth-1:0] rdata;
      logic                    error;
      logic                    ready;
   } reg_rsp_t;

   localparam logic [7:0] CTRL_OFFS    = 8'h00;
   localparam logic [7:0] STATUS_OFFS  = 8'h04;
   localparam logic [7:0] WR_CNT_OFFS  = 8'h08;
   localparam logic [7:0] RD_CNT_OFFS  = 8'h0C;
   localparam logic [7:0] BUDGET_OFFS  = 8'h10;
   localparam logic [7:0] LAST_ID_OFFS = 8'h14;

   // Member order puts en at bit 0 so the struct maps 1:1 onto the register word.
   typedef struct packed {
      logic irq_en_rd;
      logic irq_en_wr;
      logic en;
   } ctrl_reg_t;

   typedef struct packed {
      logic rd_to;
      logic wr_to;
   } status_reg_t;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_e;

endpackage

// File: rtl/slv_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment leaves 1
// so the event that raced the clear is not lost.
module slv_sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = inc_i ? Width'(1) : '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/slv_monitor_regs.sv
// Control/status registers for the AXI timeout monitor: sticky timeout flags,
// saturating counters, last offending ID, level IRQ and budget/enable outputs.
module slv_monitor_regs #(
   parameter int unsigned CntWidth    = slv_pkg::CntWidth,
   parameter int unsigned IntIdWidth  = slv_pkg::AxiIntIdWidth,
   parameter int unsigned EvtCntWidth = 16,
   parameter type         reg_req_t   = slv_pkg::reg_req_t,
   parameter type         reg_rsp_t   = slv_pkg::reg_rsp_t
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  reg_req_t              reg_req_i,
   output reg_rsp_t              reg_rsp_o,
   input  logic                  wr_timeout_i,
   input  logic                  rd_timeout_i,
   input  logic [IntIdWidth-1:0] wr_id_i,
   input  logic [IntIdWidth-1:0] rd_id_i,
   output logic                  mon_en_o,
   output logic [CntWidth-1:0]   budget_o,
   output logic                  irq_o
);

   import slv_pkg::*;

   bus_state_e              state_q, state_d;
   ctrl_reg_t               ctrl_q, ctrl_d;
   status_reg_t             status_q, status_d;
   logic [CntWidth-1:0]     budget_q, budget_d;
   logic [IntIdWidth-1:0]   last_id_q, last_id_d;
   logic                    last_vld_q, last_vld_d;
   logic [EvtCntWidth-1:0]  wr_cnt, rd_cnt;
   logic [31:0]             bit_mask;
   logic [31:0]             rdata_mux;
   logic [1:0]              w1c;
   logic [7:0]              offs;
   logic                    addr_ok, wr_commit, any_strb, wr_acc, rd_acc;
   logic                    unused_bits;

   for (genvar gi = 0; gi < 32; gi++) begin : g_mask
      assign bit_mask[gi] = reg_req_i.wstrb[gi/8];
   end

   assign unused_bits = ^{reg_req_i.wdata, bit_mask};
   assign offs        = reg_req_i.addr[7:0];
   assign any_strb    = |reg_req_i.wstrb;
   assign wr_commit   = (state_q == BUS_ACK) && reg_req_i.write && addr_ok;
   // Events are gated by the enable as it stood before any same-cycle CTRL write.
   assign wr_acc      = wr_timeout_i & ctrl_q.en;
   assign rd_acc      = rd_timeout_i & ctrl_q.en;

   always_comb begin
      addr_ok = (reg_req_i.addr[slv_pkg::RegAddrWidth-1:8] == '0) && (offs[1:0] == 2'b00);
      if (offs > LAST_ID_OFFS) addr_ok = 1'b0;
   end

   always_comb begin
      rdata_mux = '0;
      unique case (offs)
         CTRL_OFFS:    rdata_mux[2:0] = ctrl_q;
         STATUS_OFFS:  rdata_mux[1:0] = status_q;
         WR_CNT_OFFS:  rdata_mux = 32'(wr_cnt);
         RD_CNT_OFFS:  rdata_mux = 32'(rd_cnt);
         BUDGET_OFFS:  rdata_mux[CntWidth-1:0] = budget_q;
         LAST_ID_OFFS: begin
            rdata_mux[IntIdWidth-1:0] = last_id_q;
            rdata_mux[31]             = last_vld_q;
         end
         default:      rdata_mux = '0;
      endcase
   end

   always_comb begin
      ctrl_d     = ctrl_q;
      budget_d   = budget_q;
      last_id_d  = last_id_q;
      last_vld_d = last_vld_q;
      w1c        = '0;
      if (wr_commit && (offs == CTRL_OFFS)) begin
         ctrl_d = ctrl_reg_t'((ctrl_q & ~bit_mask[2:0]) | (reg_req_i.wdata[2:0] & bit_mask[2:0]));
      end
      if (wr_commit && (offs == STATUS_OFFS)) begin
         w1c = reg_req_i.wdata[1:0] & bit_mask[1:0];
      end
      if (wr_commit && (offs == BUDGET_OFFS)) begin
         budget_d = (budget_q & ~bit_mask[CntWidth-1:0])
                  | (reg_req_i.wdata[CntWidth-1:0] & bit_mask[CntWidth-1:0]);
      end
      status_d.wr_to = wr_acc | (status_q.wr_to & ~w1c[0]);
      status_d.rd_to = rd_acc | (status_q.rd_to & ~w1c[1]);
      if (wr_acc) begin
         last_id_d  = wr_id_i;
         last_vld_d = 1'b1;
      end else if (rd_acc) begin
         last_id_d  = rd_id_i;
         last_vld_d = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      reg_rsp_o = '0;
      unique case (state_q)
         BUS_IDLE: if (reg_req_i.valid) state_d = BUS_ACK;
         BUS_ACK: begin
            reg_rsp_o.ready = 1'b1;
            reg_rsp_o.error = ~addr_ok;
            if (addr_ok && !reg_req_i.write) reg_rsp_o.rdata = rdata_mux;
            state_d = BUS_IDLE;
         end
         default: state_d = BUS_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= BUS_IDLE;
         ctrl_q     <= '0;
         status_q   <= '0;
         budget_q   <= '1;
         last_id_q  <= '0;
         last_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         status_q   <= status_d;
         budget_q   <= budget_d;
         last_id_q  <= last_id_d;
         last_vld_q <= last_vld_d;
      end
   end

   slv_sat_counter #(.Width(EvtCntWidth)) u_wr_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (wr_acc),
      .clr_i (wr_commit && (offs == WR_CNT_OFFS) && any_strb),
      .cnt_o (wr_cnt)
   );

   slv_sat_counter #(.Width(EvtCntWidth)) u_rd_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (rd_acc),
      .clr_i (wr_commit && (offs == RD_CNT_OFFS) && any_strb),
      .cnt_o (rd_cnt)
   );

   assign mon_en_o = ctrl_q.en;
   assign budget_o = budget_q;
   assign irq_o    = ctrl_q.en & ((status_q.wr_to & ctrl_q.irq_en_wr) | (status_q.rd_to & ctrl_q.irq_en_rd));

endmodule

// File: tb/tb_slv_monitor_regs.sv
// Directed table plus randomized traffic against a rule-level register model.
module tb_slv_monitor_regs;

   localparam int MAXC = 15;

   logic                 clk = 1'b0;
   logic                 rst;
   slv_pkg::reg_req_t    req;
   slv_pkg::reg_rsp_t    rsp;
   logic                 wr_to, rd_to;
   logic [0:0]           wr_id, rd_id;
   logic                 mon_en, irq;
   logic [2:0]           budget;

   int checks = 0;
   int fails  = 0;

   logic [2:0]  m_ctrl;
   logic [1:0]  m_st;
   int          m_wcnt, m_rcnt;
   logic [2:0]  m_bud;
   logic [31:0] m_last;

   typedef struct {
      int          kind;      // 0 read, 1 write, 2 event-only cycle
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        ev_w, ev_r, iw, ir;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[$];

   slv_monitor_regs #(.EvtCntWidth(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .reg_req_i    (req),
      .reg_rsp_o    (rsp),
      .wr_timeout_i (wr_to),
      .rd_timeout_i (rd_to),
      .wr_id_i      (wr_id),
      .rd_id_i      (rd_id),
      .mon_en_o     (mon_en),
      .budget_o     (budget),
      .irq_o        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic addr_valid(input logic [31:0] a);
      return (a[31:8] == 24'h0) && (a[1:0] == 2'b00) && (a[7:0] <= 8'h14);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (!addr_valid(a)) return 32'h0;
      case (a[7:0])
         8'h00:   return {29'h0, m_ctrl};
         8'h04:   return {30'h0, m_st};
         8'h08:   return 32'(m_wcnt);
         8'h0C:   return 32'(m_rcnt);
         8'h10:   return {29'h0, m_bud};
         default: return m_last;
      endcase
   endfunction

   function automatic logic m_irq();
      return m_ctrl[0] & ((m_st[0] & m_ctrl[1]) | (m_st[1] & m_ctrl[2]));
   endfunction

   task automatic model_reset();
      m_ctrl = 3'h0; m_st = 2'h0; m_wcnt = 0; m_rcnt = 0; m_bud = 3'h7; m_last = 32'h0;
   endtask

   // One clock edge worth of register effects: optional committed write plus events.
   task automatic model_commit(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                               input logic [3:0] ws, input logic ew, input logic er,
                               input logic iw, input logic ir);
      logic aw, ar, we;
      logic [1:0] clr;
      aw  = ew & m_ctrl[0];
      ar  = er & m_ctrl[0];
      we  = wr & addr_valid(a);
      clr = (we && a[7:0] == 8'h04 && ws[0]) ? wd[1:0] : 2'b00;
      m_st = (m_st & ~clr) | {ar, aw};
      if (we && a[7:0] == 8'h08 && ws != 4'h0) m_wcnt = 0;
      if (we && a[7:0] == 8'h0C && ws != 4'h0) m_rcnt = 0;
      if (aw) m_wcnt = (m_wcnt + 1 > MAXC) ? MAXC : m_wcnt + 1;
      if (ar) m_rcnt = (m_rcnt + 1 > MAXC) ? MAXC : m_rcnt + 1;
      if (we && a[7:0] == 8'h00 && ws[0]) m_ctrl = wd[2:0];
      if (we && a[7:0] == 8'h10 && ws[0]) m_bud = wd[2:0];
      if (aw)      m_last = {1'b1, 30'h0, iw};
      else if (ar) m_last = {1'b1, 30'h0, ir};
   endtask

   task automatic bus_op(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic ew, input logic er,
                         input logic iw, input logic ir,
                         output logic [31:0] rdata, output logic err);
      int lat;
      req.addr = a; req.write = wr; req.wdata = wd; req.wstrb = ws; req.valid = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!rsp.ready && lat < 8);
      check("ready_latency", 32'(lat), 32'd1);
      rdata = rsp.rdata;
      err   = rsp.error;
      req.valid = 1'b0;
      wr_to = ew; rd_to = er; wr_id = iw; rd_id = ir;
      @(posedge clk);
      model_commit(a, wr, wd, ws, ew, er, iw, ir);
      #1;
      wr_to = 1'b0; rd_to = 1'b0;
      $display("txn %s addr=0x%08h wdata=0x%08h wstrb=%h ev=%b%b rdata=0x%08h err=%b",
               wr ? "W" : "R", a, wd, ws, ew, er, rdata, err);
   endtask

   task automatic ev_cycle(input logic ew, input logic er, input logic iw, input logic ir);
      wr_to = ew; rd_to = er; wr_id = iw; rd_id = ir;
      @(posedge clk);
      model_commit(32'h0, 1'b0, 32'h0, 4'h0, ew, er, iw, ir);
      #1;
      wr_to = 1'b0; rd_to = 1'b0;
      $display("txn E ev=%b%b ids=%b%b", ew, er, iw, ir);
   endtask

   task automatic post_check();
      check("irq_o", {31'h0, irq}, {31'h0, m_irq()});
      check("mon_en_o", {31'h0, mon_en}, {31'h0, m_ctrl[0]});
      check("budget_o", {29'h0, budget}, {29'h0, m_bud});
   endtask

   function automatic vec_t mk(input int k, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] ws, input logic ew, input logic er,
                               input logic iw, input logic ir, input logic [31:0] er_d,
                               input logic ee, input logic ei);
      vec_t v;
      v.kind = k; v.addr = a; v.wdata = wd; v.wstrb = ws; v.ev_w = ew; v.ev_r = er;
      v.iw = iw; v.ir = ir; v.exp_rdata = er_d; v.exp_err = ee; v.exp_irq = ei;
      return v;
   endfunction

   initial begin
      logic [31:0] rd;
      logic        err;
      logic [31:0] a;
      logic [31:0] offs_tab[6];
      int          r;

      offs_tab[0] = 32'h00; offs_tab[1] = 32'h04; offs_tab[2] = 32'h08;
      offs_tab[3] = 32'h0C; offs_tab[4] = 32'h10; offs_tab[5] = 32'h14;

      // kind addr wdata strb ew er iw ir exp_rdata exp_err exp_irq
      tbl.push_back(mk(0, 32'h00, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0));
      tbl.push_back(mk(0, 32'h04, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0));
      tbl.push_back(mk(0, 32'h08, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0));
      tbl.push_back(mk(0, 32'h0C, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0));
      tbl.push_back(mk(0, 32'h10, 0, 4'h0, 0, 0, 0, 0, 32'h7, 0, 0));
      tbl.push_back(mk(0, 32'h14, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0));
      tbl.push_back(mk(1, 32'h00, 32'h3, 4'hF, 0, 0, 0, 0, 32'h0, 0, 0));
      tbl.push_back(mk(2, 32'h00, 0, 4'h0, 1, 0, 1, 0, 32'h0, 0, 1));
      tbl.push_back(mk(0, 32'h04, 0, 4'h0, 0, 0, 0, 0, 32'h1, 0, 1));
      tbl.push_back(mk(0, 32'h08, 0, 4'h0, 0, 0, 0, 0, 32'h1, 0, 1));
      tbl.push_back(mk(0, 32'h14, 0, 4'h0, 0, 0, 0, 0, 32'h80000001, 0, 1));
      tbl.push_back(mk(1, 32'h04, 32'h1, 4'hF, 0, 0, 0, 0, 32'h0, 0, 0));
      tbl.push_back(mk(0, 32'h04, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0));
      tbl.push_back(mk(1, 32'h08, 32'h0, 4'hF, 0, 0, 0, 0, 32'h0, 0, 0));
      tbl.push_back(mk(2, 32'h00, 0, 4'h0, 1, 1, 0, 1, 32'h0, 0, 1));
      tbl.push_back(mk(0, 32'h04, 0, 4'h0, 0, 0, 0, 0, 32'h3, 0, 1));
      tbl.push_back(mk(0, 32'h08, 0, 4'h0, 0, 0, 0, 0, 32'h1, 0, 1));
      tbl.push_back(mk(0, 32'h0C, 0, 4'h0, 0, 0, 0, 0, 32'h1, 0, 1));
      tbl.push_back(mk(0, 32'h14, 0, 4'h0, 0, 0, 0, 0, 32'h80000000, 0, 1));
      tbl.push_back(mk(1, 32'h04, 32'h1, 4'hF, 1, 0, 1, 0, 32'h0, 0, 1));
      tbl.push_back(mk(0, 32'h04, 0, 4'h0, 0, 0, 0, 0, 32'h3, 0, 1));
      tbl.push_back(mk(1, 32'h08, 32'h0, 4'hF, 1, 0, 0, 0, 32'h0, 0, 1));
      tbl.push_back(mk(0, 32'h08, 0, 4'h0, 0, 0, 0, 0, 32'h1, 0, 1));
      tbl.push_back(mk(0, 32'h14, 0, 4'h0, 0, 0, 0, 0, 32'h80000000, 0, 1));
      tbl.push_back(mk(0, 32'h18, 0, 4'h0, 0, 0, 0, 0, 32'h0, 1, 1));
      tbl.push_back(mk(1, 32'h02, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 32'h0, 1, 1));
      tbl.push_back(mk(0, 32'h100, 0, 4'h0, 0, 0, 0, 0, 32'h0, 1, 1));
      tbl.push_back(mk(0, 32'h00, 0, 4'h0, 0, 0, 0, 0, 32'h3, 0, 1));
      tbl.push_back(mk(1, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 1));
      tbl.push_back(mk(0, 32'h10, 0, 4'h0, 0, 0, 0, 0, 32'h7, 0, 1));
      tbl.push_back(mk(1, 32'h10, 32'h5, 4'h1, 0, 0, 0, 0, 32'h0, 0, 1));
      tbl.push_back(mk(0, 32'h10, 0, 4'h0, 0, 0, 0, 0, 32'h5, 0, 1));
      tbl.push_back(mk(1, 32'h04, 32'h3, 4'hF, 0, 0, 0, 0, 32'h0, 0, 0));
      tbl.push_back(mk(0, 32'h04, 0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 0));

      rst = 1'b1; req = '0; wr_to = 1'b0; rd_to = 1'b0; wr_id = 1'b0; rd_id = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {31'h0, rsp.ready}, 32'h0);
      check("reset_rdata", rsp.rdata, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
      check("reset_mon_en", {31'h0, mon_en}, 32'h0);
      check("reset_budget", {29'h0, budget}, 32'h7);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         if (tbl[i].kind == 2) begin
            ev_cycle(tbl[i].ev_w, tbl[i].ev_r, tbl[i].iw, tbl[i].ir);
         end else begin
            bus_op(tbl[i].addr, tbl[i].kind == 1, tbl[i].wdata, tbl[i].wstrb, tbl[i].ev_w,
                   tbl[i].ev_r, tbl[i].iw, tbl[i].ir, rd, err);
            check($sformatf("tbl%0d_err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
            if (tbl[i].kind == 0) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
         end
         check($sformatf("tbl%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].exp_irq});
         post_check();
      end

      // Saturation, CTRL disable racing an event, then events while disabled.
      bus_op(32'h00, 1, 32'h1, 4'hF, 0, 0, 0, 0, rd, err);
      for (int k = 0; k < 20; k++) ev_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      bus_op(32'h0C, 0, 0, 4'h0, 0, 0, 0, 0, rd, err);
      check("rd_cnt_saturated", rd, 32'd15);
      bus_op(32'h00, 1, 32'h0, 4'hF, 1, 0, 1, 0, rd, err);
      bus_op(32'h08, 0, 0, 4'h0, 0, 0, 0, 0, rd, err);
      check("event_with_en_clear", rd, 32'd2);
      for (int k = 0; k < 5; k++) ev_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      bus_op(32'h08, 0, 0, 4'h0, 0, 0, 0, 0, rd, err);
      check("disabled_wr_cnt", rd, 32'd2);
      bus_op(32'h0C, 0, 0, 4'h0, 0, 0, 0, 0, rd, err);
      check("disabled_rd_cnt", rd, 32'd15);
      bus_op(32'h04, 0, 0, 4'h0, 0, 0, 0, 0, rd, err);
      check("disabled_status", rd, 32'h3);
      bus_op(32'h14, 0, 0, 4'h0, 0, 0, 0, 0, rd, err);
      check("disabled_last_id", rd, 32'h80000001);
      post_check();

      // Reset landing in the ACK cycle drops the pending write.
      req.addr = 32'h00; req.write = 1'b1; req.wdata = 32'h7; req.wstrb = 4'hF; req.valid = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_ack", {31'h0, rsp.ready}, 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", {31'h0, rsp.ready}, 32'h0);
      check("mid_rst_budget", {29'h0, budget}, 32'h7);
      req.valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      bus_op(32'h00, 0, 0, 4'h0, 0, 0, 0, 0, rd, err);
      check("mid_rst_ctrl", rd, 32'h0);

      bus_op(32'h00, 1, 32'h7, 4'hF, 0, 0, 0, 0, rd, err);
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 3) begin
            a = offs_tab[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 511);
            bus_op(a, 0, 0, 4'h0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   1'($urandom), 1'($urandom), rd, err);
            check("rnd_rd_err", {31'h0, err}, {31'h0, !addr_valid(a)});
         end else if (r <= 6) begin
            a = offs_tab[$urandom_range(0, 5)];
            if (a == 32'h00 && $urandom_range(0, 3) != 0) a = 32'h04;
            bus_op(a, 1, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), rd, err);
            check("rnd_wr_err", {31'h0, err}, 32'h0);
            a = offs_tab[$urandom_range(0, 5)];
         end else begin
            ev_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'($urandom), 1'($urandom));
            a = offs_tab[$urandom_range(0, 5)];
         end
         bus_op(a, 0, 0, 4'h0, 0, 0, 0, 0, rd, err);
         check($sformatf("rnd_rdata_0x%02h", a[7:0]), rd, m_read(a));
         post_check();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/slv_monitor_regs.md
Name: slv_monitor_regs

Overview:
Register-bus control/status block that sits directly downstream of the AXI timeout monitor. It consumes the monitor's write-timeout and read-timeout event pulses, keeps sticky status flags, saturating event counters and the last offending internal ID, and raises a level interrupt. It also supplies the timeout budget and enable back to the monitor. Software accesses it through the slave-side regbus types defined in slv_pkg.

Parameters:
CntWidth, 3, width of timeout budget value driven to monitor (slv_pkg::CntWidth)
IntIdWidth, 1, width of internal ID reported with events (slv_pkg::AxiIntIdWidth)
EvtCntWidth, 16, width of each saturating event counter (<=32)
reg_req_t, slv_pkg::reg_req_t, regbus request type (addr, write, wdata, wstrb, valid)
reg_rsp_t, slv_pkg::reg_rsp_t, regbus response type (rdata, error, ready)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
reg_req_i  in  reg_req_t  regbus request
reg_rsp_o  out  reg_rsp_t  regbus response
wr_timeout_i  in  1  single-cycle write-timeout event from monitor
rd_timeout_i  in  1  single-cycle read-timeout event from monitor
wr_id_i  in  IntIdWidth  internal ID of timed-out write, valid with wr_timeout_i
rd_id_i  in  IntIdWidth  internal ID of timed-out read, valid with rd_timeout_i
mon_en_o  out  1  monitor enable (CTRL.en)
budget_o  out  CntWidth  timeout budget to monitor
irq_o  out  1  level interrupt

Behaviour:
- Reset (rst_i high, async): all registers to reset values; FSM to IDLE; reg_rsp_o.ready=0, rdata=0, error=0; irq_o=0, mon_en_o=0, budget_o=all ones.
- Register map, 32-bit words, decode on addr[7:0]:
  0x00 CTRL RW: [0] en, [1] irq_en_wr, [2] irq_en_rd; reset 0.
  0x04 STATUS W1C: [0] wr_to, [1] rd_to; reset 0.
  0x08 WR_CNT RO: saturating write-timeout count, zero-extended; any write clears it.
  0x0C RD_CNT RO: same, for reads.
  0x10 BUDGET RW: [CntWidth-1:0]; reset all ones.
  0x14 LAST_ID RO: [IntIdWidth-1:0] last timed-out ID; [31] valid; reset 0.
  Other offset, addr[1:0]!=0, or addr[RegAddrWidth-1:8]!=0: error=1, rdata=0, no state change.
- Regbus FSM, two states:
  - IDLE: ready=0. If valid, go to ACK.
  - ACK: ready=1, rdata/error driven from decode of the held request. Writes commit at the clock edge ending ACK. Next state is always IDLE.
  - One wait state: ready asserts the cycle after valid is first seen. Back-to-back requests therefore complete every 2 cycles.
- Write strobes: writes apply per byte lane. wstrb=0 is acknowledged as a no-op. For WR_CNT/RD_CNT, the clear happens if any strobe bit is set.
- Events are accepted only when CTRL.en=1; they are ignored when en=0.
- On an accepted wr_timeout_i:
  - STATUS.wr_to is set.
  - WR_CNT increments, saturating at 2^EvtCntWidth-1 (no wrap).
  - LAST_ID is loaded with {1, wr_id_i}.
- rd_timeout_i behaves the same way on the read fields.
- Simultaneous events:
  - wr and rd in the same cycle: both flags and both counters update; LAST_ID takes wr_id_i (write priority).
  - Event and W1C clear of the same bit in the same cycle: the event wins, bit stays 1.
  - Event and counter clear in the same cycle: the counter becomes 1.
  - Event and CTRL write of en=0 in the same cycle: the event is still accepted (old en is used).
- irq_o = en & ((wr_to & irq_en_wr) | (rd_to & irq_en_rd)), driven from registers. It is high one cycle after the event and drops one cycle after the clearing write.
- Reset mid-transaction: the FSM returns to IDLE, the pending write is dropped, and the master must reissue.

Decomposition:
- In slv_pkg:
  - register offset localparams (CTRL_OFFS..LAST_ID_OFFS);
  - a ctrl_reg_t packed struct (en, irq_en_wr, irq_en_rd);
  - a status_reg_t packed struct (wr_to, rd_to).
- Reuse slv_pkg reg_req_t/reg_rsp_t.
- One sub-module, slv_sat_counter: parameterised width, with inc and clr inputs, clr+inc resolving to 1 and saturation at max. It is instantiated twice.

Test Plan:
- Reset, then read all six offsets -> CTRL=0, STATUS=0, WR_CNT=0, RD_CNT=0, BUDGET=0x7, LAST_ID=0; ready asserts exactly 1 cycle after valid.
- Write CTRL=0x3, pulse wr_timeout_i with wr_id_i=1 -> irq_o=1 the next cycle, STATUS=0x1, WR_CNT=1, LAST_ID=0x80000001. Write STATUS=0x1 -> irq_o=0.
- en=1, drive wr_timeout_i and rd_timeout_i together with wr_id=0, rd_id=1 -> STATUS=0x3, both counts=1, LAST_ID=0x80000000.
- W1C STATUS bit0 in the same cycle as a new wr_timeout_i -> STATUS[0] stays 1. Clear WR_CNT in the same cycle as an event -> WR_CNT=1.
- With EvtCntWidth=4, issue 20 rd events -> RD_CNT=15. Then issue events with en=0 -> no change.
- Read offset 0x18 and write 0x02 -> error=1, rdata=0, no register changes. Write BUDGET with wstrb=0 -> budget_o stays 0x7.
